// File: rtl/lc3b_types.sv
// Shared types for the LC-3b pipeline control slice: stall FSM states and
// stage-index constants for the stall/bubble vectors.
package lc3b_types;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IND   = 2'd2,
    FLUSH = 2'd3
  } lc3b_stall_state;

  localparam int STG_PC    = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;

  localparam int FCNT_W = 4;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and stall/bubble/flush outputs of the pipeline stall controller.
interface pipeline_stall_ctrl_if #(
  parameter int NUM_STAGES = 5
);
  logic                  if_memread;
  logic                  if_mem_resp;
  logic                  mem_memread;
  logic                  mem_memwrite;
  logic                  mem_mem_resp;
  logic                  sti_ldi_sig;
  logic                  load_use;
  logic                  br_taken;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] bubble;
  logic                  flush;
  logic                  err_timeout;
  logic [31:0]           stall_cnt;

  modport master (
    output if_memread, if_mem_resp, mem_memread, mem_memwrite, mem_mem_resp,
           sti_ldi_sig, load_use, br_taken,
    input  stall, bubble, flush, err_timeout, stall_cnt
  );

  modport slave (
    input  if_memread, if_mem_resp, mem_memread, mem_memwrite, mem_mem_resp,
           sti_ldi_sig, load_use, br_taken,
    output stall, bubble, flush, err_timeout, stall_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + ONE;
  end
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: data/instruction memory waits, load-use hazard,
// indirect access pairs and branch flush, with timeout and stall statistics.
module pipeline_stall_ctrl
  import lc3b_types::*;
#(
  parameter int NUM_STAGES   = 5,
  parameter int MEM_IDX      = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_W       = 8
) (
  input logic              clk,
  input logic              rst_n,
  pipeline_stall_ctrl_if.slave bus
);
  localparam logic [NUM_STAGES-1:0] MEM_STALL  = {NUM_STAGES{1'b1}} >> (NUM_STAGES - 1 - MEM_IDX);
  localparam logic [NUM_STAGES-1:0] MEM_BUBBLE = {{(NUM_STAGES-1){1'b0}}, 1'b1} << (MEM_IDX + 1);
  localparam logic [FCNT_W-1:0]     FCNT_INIT  = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0]     WAIT_PRE   = {{(WAIT_W-1){1'b1}}, 1'b0};

  lc3b_stall_state       state, state_next;
  logic                  pend_q, pend_next;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_next;
  logic [NUM_STAGES-1:0] stall_c, bubble_c;
  logic                  flush_c;
  logic                  dmem_pend, imem_wait, wait_inc, err_q;
  logic [WAIT_W-1:0]     wait_cnt;

  assign dmem_pend = (bus.mem_memread | bus.mem_memwrite) & ~bus.mem_mem_resp;
  assign imem_wait = bus.if_memread & ~bus.if_mem_resp;
  assign wait_inc  = (state == DWAIT) || (state == IND) || ((state == RUN) && imem_wait);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      pend_q <= 1'b0;
      fcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      pend_q <= pend_next;
      fcnt_q <= fcnt_next;
      if (wait_inc && (wait_cnt == WAIT_PRE))
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    pend_next  = pend_q;
    fcnt_next  = fcnt_q;
    stall_c    = '0;
    bubble_c   = '0;
    flush_c    = 1'b0;
    case (state)
      RUN: begin
        // A new data access takes precedence over a same-cycle branch; the
        // branch is remembered and the flush follows the final response.
        if (dmem_pend) begin
          state_next = DWAIT;
          pend_next  = bus.br_taken;
        end else begin
          if (bus.br_taken) begin
            state_next = FLUSH;
            fcnt_next  = FCNT_INIT;
          end
          if (bus.load_use) begin
            stall_c[STG_PC]     = 1'b1;
            stall_c[STG_IF_ID]  = 1'b1;
            bubble_c[STG_ID_EX] = 1'b1;
          end else if (imem_wait) begin
            stall_c[STG_PC]     = 1'b1;
            bubble_c[STG_IF_ID] = 1'b1;
          end
        end
      end
      DWAIT: begin
        stall_c  = MEM_STALL;
        bubble_c = MEM_BUBBLE;
        if (bus.br_taken)
          pend_next = 1'b1;
        if (bus.mem_mem_resp) begin
          if (bus.sti_ldi_sig) begin
            state_next = IND;
          end else if (pend_q || bus.br_taken) begin
            state_next = FLUSH;
            fcnt_next  = FCNT_INIT;
            pend_next  = 1'b0;
          end else begin
            state_next = RUN;
          end
        end
      end
      IND: begin
        stall_c    = MEM_STALL;
        bubble_c   = MEM_BUBBLE;
        state_next = DWAIT;
        if (bus.br_taken)
          pend_next = 1'b1;
      end
      FLUSH: begin
        flush_c = 1'b1;
        if (bus.br_taken)
          fcnt_next = FCNT_INIT;
        else if (fcnt_q == '0)
          state_next = RUN;
        else
          fcnt_next = fcnt_q - 1'b1;
      end
      default: state_next = RUN;
    endcase
    if (!rst_n) begin
      stall_c  = '0;
      bubble_c = '0;
      flush_c  = 1'b0;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.bubble      = bubble_c;
  assign bus.flush       = flush_c;
  assign bus.err_timeout = err_q;

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_c[STG_PC]),
    .clr   (1'b0),
    .count (bus.stall_cnt)
  );

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wait_inc),
    .clr   (~wait_inc),
    .count (wait_cnt)
  );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench for pipeline_stall_ctrl (NUM_STAGES=5, MEM_IDX=3,
// FLUSH_CYCLES=2, WAIT_W=4).
module tb_pipeline_stall_ctrl;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipeline_stall_ctrl_if #(.NUM_STAGES(5)) bus ();

  pipeline_stall_ctrl #(
    .NUM_STAGES   (5),
    .MEM_IDX      (3),
    .FLUSH_CYCLES (2),
    .WAIT_W       (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic ifr, input logic ifrs, input logic mr, input logic mw,
                        input logic mrs, input logic sti, input logic lu, input logic br);
    bus.if_memread   = ifr;
    bus.if_mem_resp  = ifrs;
    bus.mem_memread  = mr;
    bus.mem_memwrite = mw;
    bus.mem_mem_resp = mrs;
    bus.sti_ldi_sig  = sti;
    bus.load_use     = lu;
    bus.br_taken     = br;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] st, input logic [4:0] bb, input logic fl);
    #1;
    check({tag, ".stall"}, 32'(bus.stall), 32'(st));
    check({tag, ".bubble"}, 32'(bus.bubble), 32'(bb));
    check({tag, ".flush"}, 32'(bus.flush), 32'(fl));
  endtask

  task automatic do_reset;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst.stall", 32'(bus.stall), 32'h0);
    check("rst.bubble", 32'(bus.bubble), 32'h0);
    check("rst.flush", 32'(bus.flush), 32'h0);
    check("rst.err", 32'(bus.err_timeout), 32'h0);
    check("rst.cnt", bus.stall_cnt, 32'd0);
    rst_n = 1'b1;
    tick();

    // Data read, response three cycles after request.
    set_in(0, 0, 1, 0, 0, 0, 0, 0); chk_out("rd.c0", 5'b00000, 5'b00000, 0); tick();
    chk_out("rd.c1", 5'b01111, 5'b10000, 0); tick();
    chk_out("rd.c2", 5'b01111, 5'b10000, 0); tick();
    set_in(0, 0, 1, 0, 1, 0, 0, 0); chk_out("rd.c3", 5'b01111, 5'b10000, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out("rd.c4", 5'b00000, 5'b00000, 0);
    check("rd.cnt", bus.stall_cnt, 32'd3);
    tick();

    // Load-use together with an imem wait, then imem wait alone.
    set_in(1, 0, 0, 0, 0, 0, 1, 0); chk_out("lu", 5'b00011, 5'b00100, 0); tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0); chk_out("imem", 5'b00001, 5'b00010, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out("idle", 5'b00000, 5'b00000, 0);
    check("lu.cnt", bus.stall_cnt, 32'd5);
    tick();

    // LDI: two accesses of 2-cycle latency.
    set_in(0, 0, 1, 0, 0, 1, 0, 0); chk_out("ldi.c0", 5'b00000, 5'b00000, 0);
    check("ldi.s0", 32'(dut.state), 32'(RUN)); tick();
    chk_out("ldi.c1", 5'b01111, 5'b10000, 0);
    check("ldi.s1", 32'(dut.state), 32'(DWAIT)); tick();
    set_in(0, 0, 1, 0, 1, 1, 0, 0); chk_out("ldi.c2", 5'b01111, 5'b10000, 0); tick();
    set_in(0, 0, 1, 0, 0, 0, 0, 0); chk_out("ldi.c3", 5'b01111, 5'b10000, 0);
    check("ldi.s3", 32'(dut.state), 32'(IND)); tick();
    chk_out("ldi.c4", 5'b01111, 5'b10000, 0);
    check("ldi.s4", 32'(dut.state), 32'(DWAIT)); tick();
    set_in(0, 0, 1, 0, 1, 0, 0, 0); chk_out("ldi.c5", 5'b01111, 5'b10000, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out("ldi.c6", 5'b00000, 5'b00000, 0);
    check("ldi.s6", 32'(dut.state), 32'(RUN));
    check("ldi.cnt", bus.stall_cnt, 32'd10);
    tick();

    // Branch during a 4-cycle DWAIT: flush deferred until response, 2 cycles long.
    set_in(0, 0, 0, 1, 0, 0, 0, 0); tick();
    chk_out("bw.c1", 5'b01111, 5'b10000, 0); tick();
    set_in(0, 0, 0, 1, 0, 0, 0, 1); chk_out("bw.c2", 5'b01111, 5'b10000, 0); tick();
    set_in(0, 0, 0, 1, 0, 0, 0, 0); chk_out("bw.c3", 5'b01111, 5'b10000, 0); tick();
    set_in(0, 0, 0, 1, 1, 0, 0, 0); chk_out("bw.c4", 5'b01111, 5'b10000, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0); chk_out("bw.f1", 5'b00000, 5'b00000, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out("bw.f2", 5'b00000, 5'b00000, 1); tick();
    chk_out("bw.end", 5'b00000, 5'b00000, 0);
    check("bw.cnt", bus.stall_cnt, 32'd14);

    // Branch in RUN, then again inside FLUSH extends the pulse.
    set_in(0, 0, 0, 0, 0, 0, 0, 1); chk_out("br.c0", 5'b00000, 5'b00000, 0); tick();
    chk_out("br.c1", 5'b00000, 5'b00000, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); chk_out("br.c2", 5'b00000, 5'b00000, 1); tick();
    chk_out("br.c3", 5'b00000, 5'b00000, 1); tick();
    chk_out("br.c4", 5'b00000, 5'b00000, 0);

    // Timeout: read never answered, 4-bit wait counter.
    do_reset();
    set_in(0, 0, 1, 0, 0, 0, 0, 0); tick();
    for (int k = 1; k <= 15; k++) begin
      #1;
      check($sformatf("to.pre%0d", k), 32'(bus.err_timeout), 32'h0);
      tick();
    end
    #1;
    check("to.set", 32'(bus.err_timeout), 32'h1);
    check("to.stall", 32'(bus.stall), 32'h0f);
    set_in(0, 0, 1, 0, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
    #1;
    check("to.sticky", 32'(bus.err_timeout), 32'h1);
    check("to.idle", 32'(bus.stall), 32'h0);

    // Reset dropped mid-DWAIT.
    do_reset();
    set_in(0, 0, 1, 0, 0, 0, 0, 0); tick();
    chk_out("rm.dw", 5'b01111, 5'b10000, 0);
    rst_n = 1'b0;
    #1;
    check("rm.stall", 32'(bus.stall), 32'h0);
    check("rm.bubble", 32'(bus.bubble), 32'h0);
    check("rm.err", 32'(bus.err_timeout), 32'h0);
    check("rm.cnt", bus.stall_cnt, 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 1, 0); chk_out("rm.run", 5'b00011, 5'b00100, 0);
    check("rm.state", 32'(dut.state), 32'(RUN));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rm.cnt1", bus.stall_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001: Parameter NUM_STAGES, default 5, is the number of stall-controlled registers; index 0 is PC, index k is the k-th pipeline register.
REQ-002: Parameter MEM_IDX, default 3, is the index of the register feeding the data-memory stage; legal range is 1..NUM_STAGES-2.
REQ-003: Parameter FLUSH_CYCLES, default 1, is the flush pulse length in cycles; legal range is 1..15.
REQ-004: Parameter WAIT_W, default 8, is the width of the memory-wait timeout counter.
REQ-005: clk  in  1  sole clock; all state changes on its rising edge.
REQ-006: rst_n  in  1  asynchronous, active-low reset.
REQ-007: if_memread, if_mem_resp  in  1 each  instruction-memory request and response.
REQ-008: mem_memread, mem_memwrite, mem_mem_resp  in  1 each  data-memory read, write and response.
REQ-009: sti_ldi_sig  in  1  current data access is the first half of an indirect (STI/LDI) pair.
REQ-010: load_use  in  1  decode-stage source matches an execute-stage load destination.
REQ-011: br_taken  in  1  write-back redirects the PC.
REQ-012: stall  out  NUM_STAGES  per-register hold.
REQ-013: bubble  out  NUM_STAGES  per-register NOP insert; bit 0 is always 0.
REQ-014: flush  out  1  squash all pipeline registers.
REQ-015: err_timeout  out  1  sticky memory-wait timeout flag.
REQ-016: stall_cnt  out  32  saturating count of cycles with stall[0]=1.

Function
REQ-017: FSM states are RUN, DWAIT, IND and FLUSH.
REQ-018: DWAIT means dmem pending, defined as (mem_memread|mem_memwrite)&!mem_mem_resp.
  - RUN->DWAIT when dmem pending.
  - DWAIT->IND on resp with sti_ldi_sig=1.
  - DWAIT->RUN on resp with sti_ldi_sig=0.
REQ-019: IND->DWAIT on the next cycle, so the second access of the pair waits for its own resp; stalls stay asserted through IND.
REQ-020: In DWAIT and IND, stall[0..MEM_IDX]=1, bubble[MEM_IDX+1]=1, and all other stall and bubble bits are 0.
REQ-021: In RUN with dmem idle, each hazard has a fixed response; dmem wait has priority over both:
  - load_use=1: stall[0]=1, stall[1]=1, bubble[2]=1.
  - otherwise, if_memread&!if_mem_resp: stall[0]=1, bubble[1]=1.
REQ-022: In RUN with no hazard, all stall and bubble bits are 0; stall and bubble are combinational from state and inputs.
REQ-023: On br_taken in RUN, the controller enters FLUSH; flush=1 for exactly FLUSH_CYCLES consecutive cycles starting the cycle after br_taken.
REQ-024: While flush=1, all stall and bubble bits are 0; FLUSH->RUN when the flush counter expires.
REQ-025: br_taken in DWAIT or IND sets a pending-flush bit; on the final resp the FSM enters FLUSH instead of RUN.
REQ-026: br_taken in FLUSH restarts the flush counter, so the pulse extends.
REQ-027: The wait counter increments each cycle in DWAIT or IND, or in RUN with an imem wait, and clears otherwise.
REQ-028: When the wait counter reaches 2^WAIT_W-1, err_timeout sets and stays set until reset; stalls continue.
REQ-029: stall_cnt increments when stall[0]=1 and saturates at 0xFFFF_FFFF.

Reset
REQ-030: rst_n=0 asynchronously forces:
  - state RUN, pending-flush 0, all counters 0;
  - stall 0, bubble 0, flush 0, err_timeout 0, stall_cnt 0.
REQ-031: Reset mid-wait or mid-flush discards all pending work; the first cycle after release behaves as RUN.

Structure
REQ-032: The FSM state enum (lc3b_stall_state) and the stage-index constants (STG_PC, STG_IF_ID) belong in lc3b_types.
REQ-033: A single sub-module, sat_counter (parametrised width, inc, clr, saturating), is instantiated for both stall_cnt and the wait counter.

Verification
REQ-034: Data read with resp after 3 cycles -> stall[3:0]=1111 and bubble[4]=1 for 3 cycles, then all zero; stall_cnt=3.
REQ-035: LDI with two accesses of 2-cycle latency each -> stalls held for 2+1+2 cycles with state sequence DWAIT, IND, DWAIT, RUN.
REQ-036: load_use and an imem wait together -> stall=00011 and bubble=00100 (load_use wins).
REQ-037: br_taken during a 4-cycle DWAIT with FLUSH_CYCLES=2 -> no flush until resp, then flush=1 for exactly 2 cycles.
REQ-038: mem_memread held with no resp, WAIT_W=4 -> err_timeout rises at cycle 15 and persists after resp.
REQ-039: rst_n dropped mid-DWAIT -> all outputs 0 immediately; normal RUN behaviour after release.
